// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, combinational imem port, registered IF/ID {pc, instr} with valid.
// Latency: one edge from PC presentation to IF_ID; redirect target valid two edges after branch_taken.
// Backpressure: stall holds pc and IF_ID (flush still clears); FETCH_MISALIGN_TRAP_EN enables the misaligned-PC fault.
module fetch_stage #(
    parameter int                   ADDR_W     = 32,
    parameter int                   INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int                   PC_STEP    = 4,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = '1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_target,
    output logic [ADDR_W-1:0]           imem_addr,
    output logic                        imem_en,
    input  logic [INSTR_W-1:0]          imem_rdata,
    output logic [ADDR_W-1:0]           pc,
    output logic [ADDR_W+INSTR_W-1:0]   IF_ID,
    output logic                        if_id_valid,
    output logic                        halted,
    output logic                        fault
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc_inc;
    logic                misaligned;

    // Wraps modulo 2^ADDR_W by construction of the width.
    assign pc_inc    = pc + ADDR_W'(PC_STEP);
    assign imem_addr = pc;
    assign halted    = (state == S_HALTED);
    assign imem_en   = !reset && !stall && !halted && !fault;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);
    assign misaligned = |(pc & STEP_MASK);
    assign fault      = (state == S_FAULT);
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            IF_ID       <= '0;
            if_id_valid <= 1'b0;
            state       <= S_RUN;
        end else if (branch_taken) begin
            // Redirect wins over stall and squashes this cycle's fetch.
            pc          <= branch_target;
            IF_ID       <= '0;
            if_id_valid <= 1'b0;
            state       <= S_RUN;
        end else if (stall) begin
            if (flush) begin
                IF_ID       <= '0;
                if_id_valid <= 1'b0;
            end
        end else if (flush) begin
            IF_ID       <= '0;
            if_id_valid <= 1'b0;
            pc          <= pc_inc;
        end else if (state != S_RUN) begin
            IF_ID       <= '0;
            if_id_valid <= 1'b0;
        end else if (misaligned) begin
            IF_ID       <= '0;
            if_id_valid <= 1'b0;
            state       <= S_FAULT;
        end else begin
            IF_ID       <= {pc, imem_rdata};
            if_id_valid <= 1'b1;
            // The halt word itself is delivered; pc parks on it.
            if (imem_rdata == HALT_INSTR) begin
                state <= S_HALTED;
            end else begin
                pc <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: 32-bit instance at RESET_PC 0x100 plus an 8-bit instance for PC wrap.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [63:0] IF_ID;
    logic        if_id_valid;
    logic        halted;
    logic        fault;

    logic [7:0]  imem_addr8;
    logic        imem_en8;
    logic [31:0] imem_rdata8;
    logic [7:0]  pc8;
    logic [39:0] IF_ID8;
    logic        if_id_valid8;
    logic        halted8;
    logic        fault8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_010C) return 32'hFFFF_FFFF;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata  = mem(imem_addr);
    assign imem_rdata8 = {24'h0, imem_addr8};

    fetch_stage #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100), .PC_STEP(4), .HALT_INSTR(32'hFFFF_FFFF)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .pc(pc), .IF_ID(IF_ID), .if_id_valid(if_id_valid),
        .halted(halted), .fault(fault)
    );

    fetch_stage #(
        .ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .PC_STEP(4), .HALT_INSTR(32'hFFFF_FFFF)
    ) dut8 (
        .clock(clock), .reset(reset), .stall(1'b0), .flush(1'b0),
        .branch_taken(1'b0), .branch_target(8'h00),
        .imem_addr(imem_addr8), .imem_en(imem_en8), .imem_rdata(imem_rdata8),
        .pc(pc8), .IF_ID(IF_ID8), .if_id_valid(if_id_valid8),
        .halted(halted8), .fault(fault8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        step(); step();

        check("rst_pc", pc, 64'h100);
        check("rst_valid", if_id_valid, 0);
        check("rst_ifid", IF_ID, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_imem_en", imem_en, 0);
        check("rst_pc8", pc8, 64'hF8);

        reset = 1'b0;
        #1;
        check("run_imem_en", imem_en, 1);
        step();
        check("f0_ifid", IF_ID, 64'h00000100_C0DE0100);
        check("f0_valid", if_id_valid, 1);
        check("f0_pc", pc, 64'h104);
        check("w_pc8_fc", pc8, 64'hFC);
        step();
        check("f1_ifid", IF_ID, 64'h00000104_C0DE0104);
        check("f1_pc", pc, 64'h108);
        check("w_pc8_wrap", pc8, 64'h00);
        check("w_ifid8", IF_ID8, 64'hFC_000000FC);

        // Two-cycle stall at pc 0x108
        stall = 1'b1;
        #1;
        check("st_imem_en", imem_en, 0);
        step(); step();
        check("st_ifid", IF_ID, 64'h00000104_C0DE0104);
        check("st_valid", if_id_valid, 1);
        check("st_pc", pc, 64'h108);
        stall = 1'b0;
        step();
        check("st_rel_ifid", IF_ID, 64'h00000108_C0DE0108);
        check("st_rel_pc", pc, 64'h10C);

        // Halt word at 0x10C
        step();
        check("h_ifid", IF_ID, 64'h0000010C_FFFFFFFF);
        check("h_valid", if_id_valid, 1);
        check("h_halted", halted, 1);
        check("h_pc", pc, 64'h10C);
        check("h_imem_en", imem_en, 0);
        step();
        check("h2_valid", if_id_valid, 0);
        check("h2_ifid", IF_ID, 0);
        check("h2_pc", pc, 64'h10C);
        check("h2_halted", halted, 1);

        branch_taken = 1'b1; branch_target = 32'h0;
        step();
        branch_taken = 1'b0;
        check("hr_pc", pc, 64'h0);
        check("hr_halted", halted, 0);
        check("hr_valid", if_id_valid, 0);
        step();
        check("hr_ifid", IF_ID, 64'h00000000_C0DE0000);
        check("hr_valid2", if_id_valid, 1);
        check("hr_pc2", pc, 64'h4);

        // Redirect overrides stall
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        check("br_pc", pc, 64'h200);
        check("br_valid", if_id_valid, 0);
        step();
        check("br_ifid", IF_ID, 64'h00000200_C0DE0200);
        check("br_pc2", pc, 64'h204);

        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", if_id_valid, 0);
        check("fl_ifid", IF_ID, 0);
        check("fl_pc", pc, 64'h208);
        step();
        check("fl_next_ifid", IF_ID, 64'h00000208_C0DE0208);

        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        check("sf_valid", if_id_valid, 0);
        check("sf_ifid", IF_ID, 0);
        check("sf_pc", pc, 64'h20C);
        step();
        check("sf_next_ifid", IF_ID, 64'h0000020C_C0DE020C);
        check("sf_next_pc", pc, 64'h210);

        // Misaligned target
        branch_taken = 1'b1; branch_target = 32'h102;
        step();
        branch_taken = 1'b0;
        check("ma_pc", pc, 64'h102);
        check("ma_valid0", if_id_valid, 0);
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("ma_fault", fault, 1);
        check("ma_valid", if_id_valid, 0);
        check("ma_pc_hold", pc, 64'h102);
        check("ma_imem_en", imem_en, 0);
`else
        check("ma_fault", fault, 0);
        check("ma_ifid", IF_ID, 64'h00000102_C0DE0102);
        check("ma_valid", if_id_valid, 1);
        check("ma_pc_next", pc, 64'h106);
`endif

        // Reset mid-operation
        reset = 1'b1;
        step();
        check("mr_pc", pc, 64'h100);
        check("mr_valid", if_id_valid, 0);
        check("mr_fault", fault, 0);
        reset = 1'b0;
        step();
        check("mr_ifid", IF_ID, 64'h00000100_C0DE0100);
        check("mr_valid2", if_id_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage: holds the program counter, drives a combinational-read instruction memory port and registers `{pc, instr}` into the IF/ID pipeline register with a valid bit. Generalises the fixed 32/32-bit fetch with configurable widths and reset vector, plus stall, flush, branch redirect and halt detection. Sits between instruction memory and decode.

## Interface
- `ADDR_W`, 32: PC / address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset.
- `PC_STEP`, 4: PC increment in bytes; a power of two ≥ 1.
- `HALT_INSTR`, all ones (`INSTR_W` bits): encoding that halts fetch.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC and IF/ID.
- `flush` in 1: invalidate IF/ID.
- `branch_taken` in 1: redirect PC.
- `branch_target` in `ADDR_W`: redirect address.
- `imem_addr` out `ADDR_W`: equals `pc`, combinational.
- `imem_en` out 1: `!reset && !stall && !halted && !fault`.
- `imem_rdata` in `INSTR_W`: instruction at `imem_addr`, same cycle.
- `pc` out `ADDR_W`: current PC register.
- `IF_ID` out `ADDR_W+INSTR_W`: `{fetched_pc, instr}`, PC in the MSBs.
- `if_id_valid` out 1: `IF_ID` holds a real instruction.
- `halted` out 1: halt instruction fetched, fetch frozen.
- `fault` out 1: misaligned-PC fault; tied 0 unless the macro below is defined.

## Operation
- Reset values: `pc=RESET_PC`, `IF_ID=0`, `if_id_valid=0`, `halted=0`, `fault=0`.
- Per-edge priority, highest first: reset > redirect > stall > flush > halted/fault > normal.
- **Redirect** (`branch_taken=1`, overrides stall):
  - `pc<=branch_target`, `IF_ID<=0`, `if_id_valid<=0`.
  - Clears `halted` and `fault`.
  - Squashes the instruction fetched this cycle.
- **Stall**: `pc`, `IF_ID` and `if_id_valid` hold. If `flush` is also high, `IF_ID<=0` and `if_id_valid<=0`, and `pc` still holds.
- **Flush** (no stall): `IF_ID<=0`, `if_id_valid<=0`, `pc<=pc+PC_STEP`. The instruction fetched this cycle is discarded.
- **Halted or faulted**: `pc` holds, `if_id_valid<=0`, `IF_ID<=0`.
- **Normal**:
  - `IF_ID<={pc, imem_rdata}`, `if_id_valid<=1`, `pc<=pc+PC_STEP`.
  - Addition is modulo 2^`ADDR_W`; all-ones plus the step wraps silently.
- **Halt**: when `imem_rdata==HALT_INSTR` in a normal cycle:
  - The halt instruction itself is captured with `if_id_valid=1`.
  - `halted<=1` and `pc` does not advance.
- State summary: RUN, HALTED, FAULT. RUN → HALTED on halt fetch; RUN → FAULT on misalignment; HALTED/FAULT → RUN on redirect only; any state → RUN on reset.

## Timing
- Fetch latency is one cycle: the PC presented in cycle n appears in `IF_ID` after edge n.
- Redirect takes effect on the next edge; the first target instruction is valid two edges after `branch_taken` is sampled.
- Stall release resumes with the held PC; no instruction is skipped or duplicated.
- Reset mid-operation discards everything on that edge; the first valid output comes one edge after reset deasserts.
- `halted` and `fault` assert on the same edge that captures the offending cycle.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - In a normal cycle, if `pc` mod `PC_STEP != 0`, then `fault<=1`, `if_id_valid<=0` and `pc` holds.
  - Cleared only by redirect or reset.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `fault` is constant 0.
  - Low PC bits pass through unchecked and fetch proceeds normally.

## Test plan
- Reset with `RESET_PC=0x100`, then 3 free-running cycles → `IF_ID` PCs 0x100, 0x104, 0x108, each with `if_id_valid=1` and `instr` = memory contents.
- `stall` high for 2 cycles at pc=0x108 → `IF_ID` and `pc` frozen. After release, the next output PC is 0x108; no gap, no duplicate.
- `branch_taken=1` with target 0x200 while `stall=1` → next edge `pc=0x200`, `if_id_valid=0`; one edge later `IF_ID` PC is 0x200.
- Memory returns 0xFFFFFFFF at 0x10C → halt captured valid, `halted=1`, `pc` stays 0x10C, then `if_id_valid=0`. A later redirect to 0x0 clears `halted` and fetch resumes.
- `ADDR_W=8`, pc=0xFC, `PC_STEP=4` → next pc 0x00.
- With `FETCH_MISALIGN_TRAP_EN`, redirect to 0x102 → `fault=1` next edge, `if_id_valid=0`. Without the macro, `IF_ID` PC is 0x102 with valid=1.
